seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter HALF_DIV, default 512, shclk half-period in clk cycles; legal range 2..65535.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 wr_valid  in  1  host write request.
REQ-005 wr_ready  out  1  controller accepts write this cycle.
REQ-006 wr_addr  in  3  digit index 0..7.
REQ-007 wr_data  in  6  {blank, dp, hex[3:0]}.
REQ-008 ds  out  1  serial data to 74HC595 chain.
REQ-009 shclk  out  1  595 shift clock.
REQ-010 stclk  out  1  595 storage/latch clock.
REQ-011 frame_done  out  1  one-clk pulse after digit 7 is latched.

Function
REQ-012 Two 8x6 buffers, shadow and active; a write is accepted when wr_valid && wr_ready and stores wr_data at shadow[wr_addr]; a later write to the same address overwrites the earlier one.
REQ-013 Dirty flag is set by any accepted write; on the frame_done cycle, if dirty, shadow is copied to active and dirty is cleared; wr_ready is 0 in that swap cycle and 1 otherwise (outside reset).
REQ-014 Segment byte = 8'hFF if blank, else {SEG_LUT[hex][7:1], ~dp}; active-low, bit7=a..bit1=g, bit0=dp.
REQ-015 SEG_LUT (0..F) = 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex).
REQ-016 Serial word per digit = {1<<digit, seg byte}, 16 bits, shifted bit 0 first; digit select is one-hot, active-high.
REQ-017 FSM states: LOAD, SHIFT, LATCH.
REQ-018 LOAD lasts 1 clk: captures the word from active[digit], drives ds=bit0, shclk=0, stclk=0, then goes to SHIFT.
REQ-019 SHIFT: shclk toggles every HALF_DIV clks starting low; ds advances to the next bit in the same clk that shclk falls; after the 16th falling edge the FSM goes to LATCH with shclk=0.
REQ-020 LATCH: stclk=1 for HALF_DIV clks with shclk held 0, then stclk=0 and next state is LOAD with digit+1, wrapping 7->0.
REQ-021 frame_done pulses in the clk LATCH exits for digit 7.
REQ-022 Digit period = 1 + 33*HALF_DIV clks exactly; frame period = 8x that.
REQ-023 stclk and shclk are never high simultaneously; ds is stable while shclk is high.
REQ-024 A write to the digit currently shifting has no effect on the displayed frame until the next swap.

Reset
REQ-025 While rst=1: ds=0, shclk=0, stclk=0, frame_done=0, wr_ready=0, both buffers=6'b100000 (blank), dirty=0, digit=0, divider=0.
REQ-026 rst asserted mid-shift or mid-latch aborts immediately with no further edges on shclk/stclk.
REQ-027 First clk after release enters LOAD for digit 0; wr_ready=1 from that clk.

Structure
REQ-028 Package seg_pkg holds SEG_LUT, NDIG=8, WORD_W=16, the FSM state enum, and the 6-bit entry field positions.
REQ-029 The serializer (divider, bit counter, ds/shclk/stclk generation, done strobe) is sub-module seg_shift595; the top holds the buffers, handshake, digit sequencing and LUT decode.

Verification
REQ-030 HALF_DIV=2; after reset, no writes -> digit 0 word 0x01FF shifted LSB first, first stclk rise at clk 65 after release, digit period 67 clks.
REQ-031 Write addr 3, data 0x05 during frame 0 -> frame 0 digit 3 seg=FF; frame 1 digit 3 word 0x0849.
REQ-032 Write addr 2, data 0x18 (dp, hex 8) then addr 2, data 0x01 same frame -> next frame digit 2 word 0x049F (last wins, dp off).
REQ-033 wr_valid held high continuously -> wr_ready low exactly in each frame_done cycle, and no write is accepted in that cycle.
REQ-034 Assert rst during SHIFT of digit 5 -> outputs 0 in the same cycle asynchronously, buffers blank; after release, scan restarts at digit 0.
REQ-035 Protocol checker on all runs: shclk&&stclk never true, ds changes only while shclk=0, frame_done one clk wide every 536 clks.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, state type and segment decode for the 74HC595 display scanner.
package seg_pkg;

    localparam int unsigned NDIG   = 8;
    localparam int unsigned DIG_W  = 3;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned DIV_W  = 16;

    // Digit entry layout: {blank, dp, hex[3:0]}
    localparam int unsigned ENT_W       = 6;
    localparam int unsigned ENT_BLANK   = 5;
    localparam int unsigned ENT_DP      = 4;
    localparam int unsigned ENT_HEX_MSB = 3;
    localparam int unsigned ENT_HEX_LSB = 0;

    localparam logic [ENT_W-1:0] ENT_BLANK_VAL = 6'b100000;

    // Active-low segments, bit7=a .. bit1=g, bit0=dp (dp off in the table)
    localparam logic [7:0] SEG_LUT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        LATCH
    } scan_state_e;

    function automatic logic [7:0] seg_byte(input logic [ENT_W-1:0] ent);
        logic [7:0] lut_v;
        lut_v = SEG_LUT[ent[ENT_HEX_MSB:ENT_HEX_LSB]];
        if (ent[ENT_BLANK]) begin
            return 8'hFF;
        end
        return {lut_v[7:1], ~ent[ENT_DP]};
    endfunction

    // Serial word: one-hot digit select in the upper byte, segments in the lower byte
    function automatic logic [WORD_W-1:0] scan_word(input logic [DIG_W-1:0] digit,
                                                    input logic [ENT_W-1:0] ent);
        logic [7:0] sel;
        sel = 8'b1 << digit;
        return {sel, seg_byte(ent)};
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host write port of the display scanner: valid/ready handshake with address and entry.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [DIG_W-1:0] wr_addr;
    logic [ENT_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/seg_shift595.sv
// Serializer for a 74HC595 chain: loads a 16-bit word, shifts it LSB first on a
// divided shift clock, then pulses the storage clock. done_o marks the last latch cycle.
module seg_shift595
    import seg_pkg::*;
#(
    parameter int unsigned HALF_DIV = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_i,
    output logic              ds_o,
    output logic              shclk_o,
    output logic              stclk_o,
    output logic              done_o
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [3:0]       FALL_LAST = 4'(WORD_W - 1);

    scan_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        fall_q, fall_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic              shclk_q, shclk_d;
    logic              stclk_q, stclk_d;

    // ds is the shift register LSB, so it only moves on load or on a falling shclk
    assign ds_o    = sreg_q[0];
    assign shclk_o = shclk_q;
    assign stclk_o = stclk_q;

    // State and output registers; reset kills any shift or latch in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            div_q   <= '0;
            fall_q  <= '0;
            sreg_q  <= '0;
            shclk_q <= 1'b0;
            stclk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            fall_q  <= fall_d;
            sreg_q  <= sreg_d;
            shclk_q <= shclk_d;
            stclk_q <= stclk_d;
        end
    end

    // Next-state: LOAD one clk, SHIFT 32 half-periods, LATCH one half-period
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        fall_d  = fall_q;
        sreg_d  = sreg_q;
        shclk_d = shclk_q;
        stclk_d = stclk_q;
        done_o  = 1'b0;
        unique case (state_q)
            LOAD: begin
                sreg_d  = word_i;
                shclk_d = 1'b0;
                stclk_d = 1'b0;
                div_d   = '0;
                fall_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (shclk_q) begin
                        shclk_d = 1'b0;
                        sreg_d  = {1'b0, sreg_q[WORD_W-1:1]};
                        fall_d  = fall_q + 4'd1;
                        if (fall_q == FALL_LAST) begin
                            stclk_d = 1'b1;
                            state_d = LATCH;
                        end
                    end else begin
                        shclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    stclk_d = 1'b0;
                    done_o  = 1'b1;
                    state_d = LOAD;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit 7-segment scan controller: double-buffered digit entries written by the
// host, swapped at frame boundaries, decoded and streamed into a 74HC595 chain.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned HALF_DIV = 512
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave host,
    output logic           ds,
    output logic           shclk,
    output logic           stclk,
    output logic           frame_done
);

    logic [ENT_W-1:0]  shadow_q [NDIG];
    logic [ENT_W-1:0]  shadow_d [NDIG];
    logic [ENT_W-1:0]  active_q [NDIG];
    logic [ENT_W-1:0]  active_d [NDIG];
    logic              dirty_q, dirty_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic              digit_done;
    logic              wr_fire;
    logic [WORD_W-1:0] word;

    // Writes are refused only in the swap cycle so the copy never races a write
    assign frame_done    = digit_done && (digit_q == DIG_W'(NDIG - 1));
    assign host.wr_ready = ~rst & ~frame_done;
    assign wr_fire       = host.wr_valid & host.wr_ready;
    assign word          = scan_word(digit_q, active_q[digit_q]);

    seg_shift595 #(
        .HALF_DIV (HALF_DIV)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .word_i  (word),
        .ds_o    (ds),
        .shclk_o (shclk),
        .stclk_o (stclk),
        .done_o  (digit_done)
    );

    // Buffers, dirty flag and digit index registers; reset blanks both buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                shadow_q[i] <= ENT_BLANK_VAL;
                active_q[i] <= ENT_BLANK_VAL;
            end
            dirty_q <= 1'b0;
            digit_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            digit_q  <= digit_d;
        end
    end

    // Host writes land in shadow; the frame boundary publishes shadow to active
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        digit_d  = digit_q;
        if (wr_fire) begin
            shadow_d[host.wr_addr] = host.wr_data;
            dirty_d                = 1'b1;
        end
        if (frame_done && dirty_q) begin
            active_d = shadow_q;
            dirty_d  = 1'b0;
        end
        if (digit_done) begin
            digit_d = digit_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle-position reference model plus
// literal word checks and protocol checks on every cycle.
module tb_seg_scan_ctrl;

    localparam int H  = 2;
    localparam int DP = 1 + 33 * H;
    localparam int FP = 8 * DP;

    logic clk;
    logic rst;
    logic ds, shclk, stclk, frame_done;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.HALF_DIV(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (bus),
        .ds         (ds),
        .shclk      (shclk),
        .stclk      (stclk),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input int d, input logic [5:0] e);
        logic [7:0] s;
        logic [7:0] sel;
        case (e[3:0])
            4'h0: s = 8'h03; 4'h1: s = 8'h9F; 4'h2: s = 8'h25; 4'h3: s = 8'h0D;
            4'h4: s = 8'h99; 4'h5: s = 8'h49; 4'h6: s = 8'h41; 4'h7: s = 8'h1F;
            4'h8: s = 8'h01; 4'h9: s = 8'h09; 4'hA: s = 8'h11; 4'hB: s = 8'hC1;
            4'hC: s = 8'h63; 4'hD: s = 8'h85; 4'hE: s = 8'h61; default: s = 8'h71;
        endcase
        if (e[5]) s = 8'hFF;
        else      s[0] = ~e[4];
        sel = '0;
        sel[d] = 1'b1;
        return {sel, s};
    endfunction

    // Reference model state
    logic [5:0]  m_shadow [8];
    logic [5:0]  m_active [8];
    logic        m_dirty;
    logic [15:0] m_word;
    logic [15:0] cap;
    int          c;
    int          resets_seen = 0;
    logic        in_rst = 1'b0;
    logic        prev_ds = 1'b0;
    logic        st_seen;
    logic        have_fd;
    int          last_fd;

    // Compare process: sampled mid-cycle, models the following rising edge afterwards
    always @(negedge clk) begin
        int p;
        int d;
        int f;
        logic fd_exp;
        logic sh_exp;
        if (rst) begin
            if (!in_rst) resets_seen++;
            in_rst = 1'b1;
            chk("rst_ds", ds, 0);
            chk("rst_shclk", shclk, 0);
            chk("rst_stclk", stclk, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_wr_ready", bus.wr_ready, 0);
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = 6'b100000;
                m_active[i] = 6'b100000;
            end
            m_dirty = 1'b0;
            m_word  = '0;
            cap     = '0;
            c       = 0;
            st_seen = 1'b0;
            have_fd = 1'b0;
            last_fd = 0;
        end else begin
            in_rst = 1'b0;
            p = c % DP;
            d = (c / DP) % 8;
            f = c / FP;
            if (p == 0) m_word = exp_word(d, m_active[d]);
            fd_exp = ((c % FP) == FP - 1);
            sh_exp = (p >= 1 && p <= 32 * H) ? (((p - 1) / H) % 2 == 1) : 1'b0;

            chk("stclk", stclk, (p > 32 * H) ? 1 : 0);
            chk("shclk", shclk, sh_exp);
            chk("frame_done", frame_done, fd_exp);
            chk("wr_ready", bus.wr_ready, !fd_exp);
            if (p >= 1 && p <= 32 * H) chk("ds", ds, m_word[(p - 1) / (2 * H)]);

            chk("shclk_stclk_overlap", shclk & stclk, 0);
            if (shclk) chk("ds_stable_while_shclk_high", ds, prev_ds);

            if (stclk && !st_seen) begin
                chk("first_stclk_cycle", c, 65);
                st_seen = 1'b1;
            end
            if (frame_done) begin
                if (have_fd) chk("frame_done_period", c - last_fd, 536);
                last_fd = c;
                have_fd = 1'b1;
            end

            if (shclk && p >= 1 && p <= 32 * H) cap[(p - 1) / (2 * H)] = ds;
            if (p == 32 * H) begin
                if (resets_seen == 1 && f == 0 && d == 0) chk("f0_d0_word", cap, 16'h01FF);
                if (resets_seen == 1 && f == 0 && d == 3) chk("f0_d3_word", cap, 16'h08FF);
                if (resets_seen == 1 && f == 1 && d == 0) chk("f1_d0_word", cap, 16'h01FF);
                if (resets_seen == 1 && f == 1 && d == 2) chk("f1_d2_word", cap, 16'h049F);
                if (resets_seen == 1 && f == 1 && d == 3) chk("f1_d3_word", cap, 16'h0849);
                if (resets_seen == 2 && f == 0 && d == 0) chk("rst2_d0_word", cap, 16'h01FF);
                if (resets_seen == 2 && f == 0 && d == 5) chk("rst2_d5_word", cap, 16'h20FF);
            end

            // Edge at the end of this cycle
            if (bus.wr_valid && !fd_exp) begin
                m_shadow[bus.wr_addr] = bus.wr_data;
                m_dirty = 1'b1;
            end
            if (fd_exp && m_dirty) begin
                for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                m_dirty = 1'b0;
            end
            c++;
        end
        prev_ds = ds;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n);
        if (n < 2 * FP) begin
            bus.wr_valid = (n >= 100 && n <= 102);
            bus.wr_addr  = (n == 100) ? 3'd3 : 3'd2;
            bus.wr_data  = (n == 100) ? 6'h05 : ((n == 101) ? 6'h18 : 6'h01);
        end else if (n < 4 * FP) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 3'($urandom_range(0, 7));
            bus.wr_data  = 6'($urandom_range(0, 63));
        end else begin
            bus.wr_valid = ($urandom_range(0, 7) == 0);
            bus.wr_addr  = 3'($urandom_range(0, 7));
            bus.wr_data  = 6'($urandom_range(0, 63));
        end
    endtask

    // Stimulus: directed writes, continuous valid, sparse random, mid-shift reset
    initial begin
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        repeat (3) tick();
        rst = 1'b0;
        for (int n = 0; n < 6 * FP + 5 * DP + 31; n++) begin
            drive(n);
            tick();
        end
        rst          = 1'b1;
        bus.wr_valid = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int n = 0; n < 2 * FP + 100; n++) begin
            bus.wr_valid = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = 3'($urandom_range(0, 7));
            bus.wr_data  = 6'($urandom_range(0, 63));
            tick();
        end
        bus.wr_valid = 1'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
